// File: rtl/minisrc_control_unit.sv
// Multi-cycle control sequencer for the MiniSRC datapath: walks each instruction
// through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives every datapath control line.
module minisrc_control_unit #(
    parameter int unsigned STALL_LIMIT = 0
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic [31:0] ir,
    input  logic        alu_zero,
    input  logic        rz_b31,
    input  logic        imem_ready,
    input  logic        mem_ready,
    output logic        instruction_mem_read,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_enable,
    output logic        ra_enable,
    output logic        rb_enable,
    output logic        rz0_enable,
    output logic        rz1_enable,
    output logic        rlo_enable,
    output logic        rm_enable,
    output logic        ry_enable,
    output logic        rpc_enable,
    output logic        rpc_temp_enable,
    output logic        rf_write,
    output logic        mb_select,
    output logic        minc_select,
    output logic        mpc_select,
    output logic [1:0]  mc_select,
    output logic [2:0]  my_select,
    output logic [3:0]  alu_control,
    output logic        halted,
    output logic        illegal_op,
    output logic        bus_error
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK,
        HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_DIV = 4'd4;
    localparam logic [3:0] ALU_MUL = 4'd5;

    state_t      state, state_next;
    logic [31:0] stall_cnt;
    logic        z_q;
    logic        bus_error_q;

    logic [4:0]  op;
    logic [1:0]  cond;
    logic        unused_ir_bits;

    logic is_rtype, is_imm, is_ld, is_st, is_muldiv, is_br;
    logic is_jr, is_jal, is_mfhi, is_mflo, is_nop, is_halt;
    logic supported, writes_ry, is_mem_op;
    logic stall_active, stall_timeout, branch_taken;
    logic [3:0] alu_op;

    assign op             = ir[31:27];
    assign cond           = ir[20:19];
    assign unused_ir_bits = ^{ir[26:21], ir[18:0]};

    // Opcode classification shared by the next-state and output logic
    always_comb begin
        is_rtype  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
        is_imm    = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
        is_ld     = (op == OP_LD);
        is_st     = (op == OP_ST);
        is_muldiv = (op == OP_MUL) || (op == OP_DIV);
        is_br     = (op == OP_BR);
        is_jr     = (op == OP_JR);
        is_jal    = (op == OP_JAL);
        is_mfhi   = (op == OP_MFHI);
        is_mflo   = (op == OP_MFLO);
        is_nop    = (op == OP_NOP);
        is_halt   = (op == OP_HALT);
        is_mem_op = is_ld || is_st;
        writes_ry = is_rtype || is_imm || is_ld || is_mfhi || is_mflo || is_jal;
        supported = is_rtype || is_imm || is_mem_op || is_muldiv || is_br ||
                    is_jr || is_jal || is_mfhi || is_mflo || is_nop || is_halt;
    end

    always_comb begin
        alu_op = ALU_ADD;
        case (op)
            OP_SUB:          alu_op = ALU_SUB;
            OP_OR, OP_ORI:   alu_op = ALU_OR;
            OP_AND, OP_ANDI: alu_op = ALU_AND;
            OP_DIV:          alu_op = ALU_DIV;
            OP_MUL:          alu_op = ALU_MUL;
            default:         alu_op = ALU_ADD;
        endcase
    end

    // Branch condition uses the zero flag captured in EXECUTE, sign bit live from RZ
    always_comb begin
        branch_taken = 1'b0;
        case (cond)
            2'b00: branch_taken = z_q;
            2'b01: branch_taken = !z_q;
            2'b10: branch_taken = !rz_b31 && !z_q;
            2'b11: branch_taken = rz_b31;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        stall_active = ((state == FETCH) && !imem_ready) ||
                       ((state == MEMORY) && is_mem_op && !mem_ready);
        stall_timeout = (STALL_LIMIT != 0) && stall_active &&
                        ((stall_cnt + 32'd1) == STALL_LIMIT);
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state       <= IDLE;
            stall_cnt   <= '0;
            z_q         <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state <= state_next;
            if (stall_active && !stall_timeout && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end else if (!stall_active || stall_timeout) begin
                stall_cnt <= '0;
            end
            if ((state == EXECUTE) && is_br) begin
                z_q <= alu_zero;
            end
            if (stall_timeout) begin
                bus_error_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (stall_timeout) begin
                    state_next = HALT;
                end else if (imem_ready) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (is_halt) begin
                    state_next = HALT;
                end else if (!supported) begin
                    state_next = FETCH;
                end else begin
                    state_next = EXECUTE;
                end
            end
            EXECUTE: state_next = MEMORY;
            MEMORY: begin
                if (stall_timeout) begin
                    state_next = HALT;
                end else if (!is_mem_op || mem_ready) begin
                    state_next = WRITEBACK;
                end
            end
            WRITEBACK: state_next = FETCH;
            HALT:      state_next = HALT;
            default:   state_next = IDLE;
        endcase
    end

    // Every control line defaults low; each state raises only what it needs
    always_comb begin
        instruction_mem_read = 1'b0;
        mem_read             = 1'b0;
        mem_write            = 1'b0;
        ir_enable            = 1'b0;
        ra_enable            = 1'b0;
        rb_enable            = 1'b0;
        rz0_enable           = 1'b0;
        rz1_enable           = 1'b0;
        rlo_enable           = 1'b0;
        rm_enable            = 1'b0;
        ry_enable            = 1'b0;
        rpc_enable           = 1'b0;
        rpc_temp_enable      = 1'b0;
        rf_write             = 1'b0;
        mb_select            = 1'b0;
        minc_select          = 1'b0;
        mpc_select           = 1'b0;
        mc_select            = 2'd0;
        my_select            = 3'd0;
        alu_control          = 4'd0;
        illegal_op           = 1'b0;
        halted               = (state == HALT);
        bus_error            = bus_error_q;

        case (state)
            FETCH: begin
                instruction_mem_read = 1'b1;
                if (imem_ready) begin
                    ir_enable   = 1'b1;
                    rpc_enable  = 1'b1;
                    minc_select = 1'b0;
                    mpc_select  = 1'b1;
                end
            end
            DECODE: begin
                ra_enable       = 1'b1;
                rb_enable       = 1'b1;
                rpc_temp_enable = 1'b1;
                illegal_op      = !supported;
            end
            EXECUTE: begin
                alu_control = alu_op;
                if (is_rtype) begin
                    rz0_enable = 1'b1;
                end
                if (is_imm || is_mem_op || is_br) begin
                    mb_select  = 1'b1;
                    rz0_enable = 1'b1;
                end
                if (is_st) begin
                    rm_enable = 1'b1;
                end
                if (is_muldiv) begin
                    rz1_enable = 1'b1;
                    rlo_enable = 1'b1;
                end
            end
            MEMORY: begin
                if (is_ld) begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        my_select = 3'd2;
                        ry_enable = 1'b1;
                    end
                end
                if (is_st) begin
                    mem_write = 1'b1;
                end
                if (is_rtype || is_imm) begin
                    my_select = 3'd0;
                    ry_enable = 1'b1;
                end
                if (is_mfhi) begin
                    my_select = 3'd1;
                    ry_enable = 1'b1;
                end
                if (is_mflo) begin
                    my_select = 3'd3;
                    ry_enable = 1'b1;
                end
                if (is_jal) begin
                    my_select  = 3'd4;
                    ry_enable  = 1'b1;
                    rpc_enable = 1'b1;
                    mpc_select = 1'b0;
                end
                if (is_jr) begin
                    rpc_enable = 1'b1;
                    mpc_select = 1'b0;
                end
                if (is_br && branch_taken) begin
                    rpc_enable  = 1'b1;
                    minc_select = 1'b1;
                    mpc_select  = 1'b1;
                end
            end
            WRITEBACK: begin
                rf_write  = writes_ry;
                mc_select = is_jal ? 2'd3 : 2'd0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_minisrc_control_unit.sv
// Scoreboard bench for minisrc_control_unit: stimulus queues expected control words,
// an independent monitor samples the DUT mid-cycle (or just after reset assertion) and compares.
module tb_minisrc_control_unit;

    logic        iClk = 1'b0;
    logic        nRst;
    logic [31:0] ir;
    logic        alu_zero, rz_b31, imem_ready, mem_ready;

    logic instruction_mem_read, mem_read, mem_write, ir_enable, ra_enable, rb_enable;
    logic rz0_enable, rz1_enable, rlo_enable, rm_enable, ry_enable, rpc_enable;
    logic rpc_temp_enable, rf_write, mb_select, minc_select, mpc_select;
    logic [1:0] mc_select;
    logic [2:0] my_select;
    logic [3:0] alu_control;
    logic halted, illegal_op, bus_error;

    always #5 iClk = ~iClk;

    minisrc_control_unit #(.STALL_LIMIT(4)) dut (
        .iClk(iClk), .nRst(nRst), .ir(ir), .alu_zero(alu_zero), .rz_b31(rz_b31),
        .imem_ready(imem_ready), .mem_ready(mem_ready),
        .instruction_mem_read(instruction_mem_read), .mem_read(mem_read), .mem_write(mem_write),
        .ir_enable(ir_enable), .ra_enable(ra_enable), .rb_enable(rb_enable),
        .rz0_enable(rz0_enable), .rz1_enable(rz1_enable), .rlo_enable(rlo_enable),
        .rm_enable(rm_enable), .ry_enable(ry_enable), .rpc_enable(rpc_enable),
        .rpc_temp_enable(rpc_temp_enable), .rf_write(rf_write), .mb_select(mb_select),
        .minc_select(minc_select), .mpc_select(mpc_select), .mc_select(mc_select),
        .my_select(my_select), .alu_control(alu_control), .halted(halted),
        .illegal_op(illegal_op), .bus_error(bus_error)
    );

    typedef struct packed {
        logic       imem_rd, mem_rd, mem_wr, ir_en, ra_en, rb_en, rz0_en, rz1_en, rlo_en;
        logic       rm_en, ry_en, rpc_en, rpct_en, rf_wr, mb_sel, minc_sel, mpc_sel;
        logic [1:0] mc_sel;
        logic [2:0] my_sel;
        logic [3:0] alu;
        logic       halt, illegal, bus_err;
    } ctl_t;

    typedef struct {
        string name;
        ctl_t  exp;
        ctl_t  mask;
    } chk_t;

    ctl_t obs;
    assign obs = {instruction_mem_read, mem_read, mem_write, ir_enable, ra_enable, rb_enable,
                  rz0_enable, rz1_enable, rlo_enable, rm_enable, ry_enable, rpc_enable,
                  rpc_temp_enable, rf_write, mb_select, minc_select, mpc_select, mc_select,
                  my_select, alu_control, halted, illegal_op, bus_error};

    chk_t sb[$];
    int   checks_total  = 0;
    int   checks_passed = 0;
    ctl_t full_mask;
    ctl_t no_imem_mask;
    ctl_t e;

    function automatic ctl_t e_fetch();
        ctl_t x = '0;
        x.imem_rd = 1'b1; x.ir_en = 1'b1; x.rpc_en = 1'b1; x.mpc_sel = 1'b1;
        return x;
    endfunction

    function automatic ctl_t e_fetch_wait();
        ctl_t x = '0;
        x.imem_rd = 1'b1;
        return x;
    endfunction

    function automatic ctl_t e_decode();
        ctl_t x = '0;
        x.ra_en = 1'b1; x.rb_en = 1'b1; x.rpct_en = 1'b1;
        return x;
    endfunction

    function automatic ctl_t e_wb(input logic rf, input logic [1:0] mc);
        ctl_t x = '0;
        x.rf_wr = rf; x.mc_sel = mc;
        return x;
    endfunction

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [18:0] c);
        return {op, ra, rb, c};
    endfunction

    task automatic expectNow(input string name, input ctl_t exp, input ctl_t mask);
        chk_t c;
        c.name = name; c.exp = exp; c.mask = mask;
        sb.push_back(c);
    endtask

    task automatic applyStimulus(input string name, input ctl_t exp, input ctl_t mask);
        expectNow(name, exp, mask);
        @(posedge iClk);
        #1;
    endtask

    task automatic checkOutput(input chk_t c);
        logic [$bits(ctl_t)-1:0] got, want, m;
        got  = obs;
        want = c.exp;
        m    = c.mask;
        checks_total++;
        if ((got & m) === (want & m)) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %h required %h (mask %h)", c.name, got & m, want & m, m);
        end
    endtask

    task automatic fetchDecode(input string tag, input logic [31:0] instr);
        ir = instr;
        imem_ready = 1'b1;
        applyStimulus({tag, " fetch"}, e_fetch(), no_imem_mask);
        imem_ready = 1'b0;
        applyStimulus({tag, " decode"}, e_decode(), full_mask);
    endtask

    task automatic resetMidCycle(input string tag);
        @(negedge iClk);
        #2;
        expectNow({tag, " async reset"}, '0, full_mask);
        nRst = 1'b0;
        @(posedge iClk);
        #1;
        nRst = 1'b1;
        applyStimulus({tag, " idle after release"}, '0, full_mask);
    endtask

    // Monitor: sample mid-cycle, or just after reset falls to catch the asynchronous drop
    initial begin
        chk_t c;
        forever begin
            @(negedge iClk or negedge nRst);
            #1;
            if (sb.size() > 0) begin
                c = sb.pop_front();
                checkOutput(c);
            end
        end
    end

    initial begin
        full_mask = '1;
        no_imem_mask = '1;
        no_imem_mask.imem_rd = 1'b0;
        nRst = 1'b0; ir = '0; alu_zero = 0; rz_b31 = 0; imem_ready = 0; mem_ready = 0;
        repeat (2) @(posedge iClk);
        #1;
        applyStimulus("reset state", '0, full_mask);
        nRst = 1'b1;
        applyStimulus("idle after release", '0, full_mask);

        // add R1,R2,R3
        fetchDecode("add", 32'h1891_8000);
        e = '0; e.rz0_en = 1; e.alu = 4'd0;
        applyStimulus("add execute", e, full_mask);
        e = '0; e.ry_en = 1; e.my_sel = 3'd0;
        applyStimulus("add memory", e, full_mask);
        applyStimulus("add writeback", e_wb(1'b1, 2'd0), full_mask);

        // ori R4,R5,0x55
        fetchDecode("ori", enc(5'b01110, 4'd4, 4'd5, 19'h55));
        e = '0; e.mb_sel = 1; e.rz0_en = 1; e.alu = 4'd2;
        applyStimulus("ori execute", e, full_mask);
        e = '0; e.ry_en = 1;
        applyStimulus("ori memory", e, full_mask);
        applyStimulus("ori writeback", e_wb(1'b1, 2'd0), full_mask);

        // ld with three wait cycles
        fetchDecode("ld", enc(5'b00000, 4'd1, 4'd2, 19'd8));
        e = '0; e.mb_sel = 1; e.rz0_en = 1;
        applyStimulus("ld execute", e, full_mask);
        mem_ready = 1'b0;
        e = '0; e.mem_rd = 1;
        for (int i = 0; i < 3; i++) applyStimulus("ld memory wait", e, full_mask);
        mem_ready = 1'b1;
        e = '0; e.mem_rd = 1; e.ry_en = 1; e.my_sel = 3'd2;
        applyStimulus("ld memory ready", e, full_mask);
        mem_ready = 1'b0;
        applyStimulus("ld writeback", e_wb(1'b1, 2'd0), full_mask);

        // brzr taken: zero captured in EXECUTE, flag flipped afterwards
        fetchDecode("brzr t", enc(5'b10011, 4'd0, 4'b0000, 19'd16));
        alu_zero = 1'b1;
        e = '0; e.mb_sel = 1; e.rz0_en = 1;
        applyStimulus("brzr t execute", e, full_mask);
        alu_zero = 1'b0;
        e = '0; e.rpc_en = 1; e.minc_sel = 1; e.mpc_sel = 1;
        applyStimulus("brzr t memory", e, full_mask);
        applyStimulus("brzr t writeback", '0, full_mask);

        // brzr not taken
        fetchDecode("brzr n", enc(5'b10011, 4'd0, 4'b0000, 19'd16));
        alu_zero = 1'b0;
        e = '0; e.mb_sel = 1; e.rz0_en = 1;
        applyStimulus("brzr n execute", e, full_mask);
        alu_zero = 1'b1;
        applyStimulus("brzr n memory", '0, full_mask);
        alu_zero = 1'b0;
        applyStimulus("brzr n writeback", '0, full_mask);

        // brmi taken on negative RZ
        fetchDecode("brmi", enc(5'b10011, 4'd3, 4'b0011, 19'd4));
        e = '0; e.mb_sel = 1; e.rz0_en = 1;
        applyStimulus("brmi execute", e, full_mask);
        rz_b31 = 1'b1;
        e = '0; e.rpc_en = 1; e.minc_sel = 1; e.mpc_sel = 1;
        applyStimulus("brmi memory", e, full_mask);
        rz_b31 = 1'b0;
        applyStimulus("brmi writeback", '0, full_mask);

        // brpl not taken on negative RZ
        fetchDecode("brpl", enc(5'b10011, 4'd3, 4'b0010, 19'd4));
        e = '0; e.mb_sel = 1; e.rz0_en = 1;
        applyStimulus("brpl execute", e, full_mask);
        rz_b31 = 1'b1;
        applyStimulus("brpl memory", '0, full_mask);
        rz_b31 = 1'b0;
        applyStimulus("brpl writeback", '0, full_mask);

        // jal R5
        fetchDecode("jal", enc(5'b10101, 4'd5, 4'd0, 19'd0));
        applyStimulus("jal execute", '0, full_mask);
        e = '0; e.my_sel = 3'd4; e.ry_en = 1; e.rpc_en = 1; e.mpc_sel = 0;
        applyStimulus("jal memory", e, full_mask);
        applyStimulus("jal writeback", e_wb(1'b1, 2'd3), full_mask);

        // unsupported opcode returns straight to FETCH
        ir = 32'hF800_0000;
        imem_ready = 1'b1;
        applyStimulus("illegal fetch", e_fetch(), no_imem_mask);
        imem_ready = 1'b0;
        e = e_decode(); e.illegal = 1;
        applyStimulus("illegal decode", e, full_mask);

        // st interrupted by reset while the write strobe is up
        fetchDecode("st after illegal", enc(5'b00010, 4'd6, 4'd7, 19'd12));
        e = '0; e.mb_sel = 1; e.rz0_en = 1; e.rm_en = 1;
        applyStimulus("st execute", e, full_mask);
        mem_ready = 1'b0;
        e = '0; e.mem_wr = 1;
        expectNow("st memory wait", e, full_mask);
        resetMidCycle("st");

        // halt parks the sequencer until reset
        fetchDecode("halt", enc(5'b11011, 4'd0, 4'd0, 19'd0));
        imem_ready = 1'b1;
        e = '0; e.halt = 1;
        for (int i = 0; i < 3; i++) applyStimulus("halt persists", e, full_mask);
        imem_ready = 1'b0;
        resetMidCycle("halt");

        // instruction fetch stall timeout
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus("stall fetch wait", e_fetch_wait(), full_mask);
        applyStimulus("stall last wait", e_fetch_wait(), no_imem_mask);
        e = '0; e.halt = 1; e.bus_err = 1;
        for (int i = 0; i < 3; i++) applyStimulus("bus error halt", e, full_mask);
        imem_ready = 1'b1;
        applyStimulus("bus error sticky", e, full_mask);
        imem_ready = 1'b0;
        resetMidCycle("bus error");

        repeat (2) @(posedge iClk);
        #1;
        checks_total++;
        if (sb.size() == 0) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL scoreboard drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
